// File: rtl/fcvt_f2i_if.sv
// Request/result bundle for the float-to-integer converter.
// The master drives the request, the slave returns the result and status.
interface fcvt_f2i_if;
    logic        in_valid;
    logic [31:0] f;
    logic        is_unsigned;
    logic [2:0]  rm;
    logic        busy;
    logic        out_valid;
    logic [31:0] rd;
    logic        nv;
    logic        nx;

    modport master (
        output in_valid, f, is_unsigned, rm,
        input  busy, out_valid, rd, nv, nx
    );

    modport slave (
        input  in_valid, f, is_unsigned, rm,
        output busy, out_valid, rd, nv, nx
    );
endinterface

// File: rtl/fcvt_f2i.sv
// Multi-cycle IEEE-754 single to int32/uint32 converter.
// The significand is shifted one bit per cycle, then rounded once and range-checked.
module fcvt_f2i (
    input  logic       CLK,
    input  logic       RST,
    fcvt_f2i_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, ROUND} state_t;

    state_t      state;
    logic [32:0] mag;
    logic [4:0]  cnt;
    logic        guard;
    logic        sticky;
    logic        sign;
    logic        uns;
    logic        special;
    logic        nan;
    logic        left;
    logic [2:0]  rm_r;

    logic [7:0]  ex;
    logic        dec_special;
    logic        dec_left;
    logic [4:0]  dec_n;

    assign ex = bus.f[30:23];

    // Shift plan from the biased exponent: 150 is e=23, 159 is e=32; subnormals share exp=1's scale.
    always_comb begin
        dec_special = 1'b0;
        dec_left    = 1'b0;
        dec_n       = 5'd0;
        if (ex == 8'hFF || ex >= 8'd159) begin
            dec_special = 1'b1;
        end else if (ex >= 8'd150) begin
            dec_left = 1'b1;
            dec_n    = 5'(ex - 8'd150);
        end else if (ex <= 8'd125) begin
            dec_n = 5'd25;
        end else begin
            dec_n = 5'(8'd150 - ex);
        end
    end

    logic        inc;
    logic [32:0] rounded;
    logic        res_nv;
    logic [31:0] res_rd;

    always_comb begin
        case (rm_r)
            3'b001:  inc = 1'b0;
            3'b010:  inc = sign & (guard | sticky);
            3'b011:  inc = ~sign & (guard | sticky);
            3'b100:  inc = guard;
            default: inc = guard & (sticky | mag[0]);
        endcase
        rounded = mag + 33'(inc);

        res_nv = special;
        if (uns) begin
            if (rounded[32] || (sign && rounded != 33'd0))
                res_nv = 1'b1;
        end else begin
            if (!sign && rounded > 33'h07FFFFFFF)
                res_nv = 1'b1;
            if (sign && rounded > 33'h080000000)
                res_nv = 1'b1;
        end

        // NaN saturates toward the positive limit regardless of its sign bit.
        if (res_nv) begin
            if (nan || !sign)
                res_rd = uns ? 32'hFFFFFFFF : 32'h7FFFFFFF;
            else
                res_rd = uns ? 32'h00000000 : 32'h80000000;
        end else if (sign) begin
            res_rd = uns ? 32'h00000000 : (32'd0 - rounded[31:0]);
        end else begin
            res_rd = rounded[31:0];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            mag           <= '0;
            cnt           <= '0;
            guard         <= 1'b0;
            sticky        <= 1'b0;
            sign          <= 1'b0;
            uns           <= 1'b0;
            special       <= 1'b0;
            nan           <= 1'b0;
            left          <= 1'b0;
            rm_r          <= '0;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.rd        <= '0;
            bus.nv        <= 1'b0;
            bus.nx        <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mag      <= {9'b0, ex != 8'd0, bus.f[22:0]};
                        cnt      <= dec_n;
                        guard    <= 1'b0;
                        sticky   <= 1'b0;
                        sign     <= bus.f[31];
                        uns      <= bus.is_unsigned;
                        rm_r     <= bus.rm;
                        special  <= dec_special;
                        nan      <= (ex == 8'hFF) && (bus.f[22:0] != 23'd0);
                        left     <= dec_left;
                        bus.busy <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != 5'd0) begin
                        if (left) begin
                            mag <= mag << 1;
                        end else begin
                            mag    <= mag >> 1;
                            guard  <= mag[0];
                            sticky <= sticky | guard;
                        end
                        cnt <= cnt - 5'd1;
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    bus.rd        <= res_rd;
                    bus.nv        <= res_nv;
                    bus.nx        <= (guard | sticky) & ~res_nv;
                    bus.out_valid <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fcvt_f2i.sv
// Directed-vector bench for fcvt_f2i: results, flags, latency, reset abort and request handshake.
module tb_fcvt_f2i;
    logic CLK = 1'b0;
    logic RST;

    fcvt_f2i_if bus ();

    fcvt_f2i dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] f;
        logic        u;
        logic [2:0]  rm;
        logic [31:0] rd;
        logic        nv;
        logic        nx;
        int          lat;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    // Issues one request and waits (bounded) for the result; lat is edges after accept, -1 on timeout.
    task automatic run_conv(input logic [31:0] fv, input logic u, input logic [2:0] r,
                            output logic [31:0] o_rd, output logic o_nv, output logic o_nx,
                            output logic o_busy, output int lat);
        bus.f           = fv;
        bus.is_unsigned = u;
        bus.rm          = r;
        bus.in_valid    = 1'b1;
        @(posedge CLK);
        #1;
        bus.in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge CLK);
            #1;
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
        o_rd   = bus.rd;
        o_nv   = bus.nv;
        o_nx   = bus.nx;
        o_busy = bus.busy;
    endtask

    task automatic test_reset();
        RST             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.f           = 32'h0;
        bus.is_unsigned = 1'b0;
        bus.rm          = 3'd0;
        #1;
        vectors++;
        if ({bus.busy, bus.out_valid, bus.rd, bus.nv, bus.nx} !== 36'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_async: busy=%b ov=%b rd=%h nv=%b nx=%b, expected all zero",
                     bus.busy, bus.out_valid, bus.rd, bus.nv, bus.nx);
        end
        bus.in_valid = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        vectors++;
        if ({bus.busy, bus.out_valid, bus.rd, bus.nv, bus.nx} !== 36'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_held: busy=%b ov=%b rd=%h nv=%b nx=%b, expected all zero",
                     bus.busy, bus.out_valid, bus.rd, bus.nv, bus.nx);
        end
        bus.in_valid = 1'b0;
        RST = 1'b0;
    endtask

    task automatic test_rounding();
        vec_t t [11];
        logic [31:0] ord;
        logic onv, onx, ob;
        int lat;
        t[0]  = '{32'h40490FDB, 1'b0, 3'd0, 32'd3,        1'b0, 1'b1, 24};
        t[1]  = '{32'h3FC00000, 1'b0, 3'd0, 32'd2,        1'b0, 1'b1, 25};
        t[2]  = '{32'h3FC00000, 1'b0, 3'd1, 32'd1,        1'b0, 1'b1, 25};
        t[3]  = '{32'h3FC00000, 1'b0, 3'd7, 32'd2,        1'b0, 1'b1, 25};
        t[4]  = '{32'h40200000, 1'b0, 3'd0, 32'd2,        1'b0, 1'b1, 24};
        t[5]  = '{32'h40200000, 1'b0, 3'd4, 32'd3,        1'b0, 1'b1, 24};
        t[6]  = '{32'h40200000, 1'b0, 3'd2, 32'd2,        1'b0, 1'b1, 24};
        t[7]  = '{32'hC0200000, 1'b0, 3'd2, 32'hFFFFFFFD, 1'b0, 1'b1, 24};
        t[8]  = '{32'hC0200000, 1'b0, 3'd3, 32'hFFFFFFFE, 1'b0, 1'b1, 24};
        t[9]  = '{32'hC0200000, 1'b0, 3'd1, 32'hFFFFFFFE, 1'b0, 1'b1, 24};
        t[10] = '{32'h00000001, 1'b0, 3'd3, 32'd1,        1'b0, 1'b1, 27};
        foreach (t[i]) begin
            run_conv(t[i].f, t[i].u, t[i].rm, ord, onv, onx, ob, lat);
            vectors++;
            if ({ord, onv, onx, ob} !== {t[i].rd, t[i].nv, t[i].nx, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL rounding[%0d] f=%h rm=%0d: rd=%h nv=%b nx=%b busy=%b, expected rd=%h nv=%b nx=%b busy=0",
                         i, t[i].f, t[i].rm, ord, onv, onx, ob, t[i].rd, t[i].nv, t[i].nx);
            end
            vectors++;
            if (lat != t[i].lat) begin
                miscompares++;
                $display("[TB] FAIL rounding_latency[%0d]: got %0d edges, expected %0d", i, lat, t[i].lat);
            end
        end
    endtask

    task automatic test_limits();
        vec_t t [9];
        logic [31:0] ord;
        logic onv, onx, ob;
        int lat;
        t[0] = '{32'hCF000000, 1'b0, 3'd0, 32'h80000000, 1'b0, 1'b0, 10};
        t[1] = '{32'h4F000000, 1'b0, 3'd0, 32'h7FFFFFFF, 1'b1, 1'b0, 10};
        t[2] = '{32'h4F000000, 1'b1, 3'd0, 32'h80000000, 1'b0, 1'b0, 10};
        t[3] = '{32'h4F7FFFFF, 1'b1, 3'd0, 32'hFFFFFF00, 1'b0, 1'b0, 10};
        t[4] = '{32'h4B000000, 1'b0, 3'd0, 32'h00800000, 1'b0, 1'b0, 2};
        t[5] = '{32'hBF800000, 1'b1, 3'd0, 32'h00000000, 1'b1, 1'b0, 25};
        t[6] = '{32'hBF000000, 1'b1, 3'd1, 32'h00000000, 1'b0, 1'b1, 26};
        t[7] = '{32'hBF000000, 1'b1, 3'd2, 32'h00000000, 1'b1, 1'b0, 26};
        t[8] = '{32'h80000000, 1'b0, 3'd0, 32'h00000000, 1'b0, 1'b0, 27};
        foreach (t[i]) begin
            run_conv(t[i].f, t[i].u, t[i].rm, ord, onv, onx, ob, lat);
            vectors++;
            if ({ord, onv, onx, ob} !== {t[i].rd, t[i].nv, t[i].nx, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL limits[%0d] f=%h u=%b rm=%0d: rd=%h nv=%b nx=%b busy=%b, expected rd=%h nv=%b nx=%b busy=0",
                         i, t[i].f, t[i].u, t[i].rm, ord, onv, onx, ob, t[i].rd, t[i].nv, t[i].nx);
            end
            vectors++;
            if (lat != t[i].lat) begin
                miscompares++;
                $display("[TB] FAIL limits_latency[%0d]: got %0d edges, expected %0d", i, lat, t[i].lat);
            end
        end
    endtask

    task automatic test_special();
        vec_t t [6];
        logic [31:0] ord;
        logic onv, onx, ob;
        int lat;
        t[0] = '{32'h7FC00000, 1'b0, 3'd0, 32'h7FFFFFFF, 1'b1, 1'b0, 2};
        t[1] = '{32'h7FC00000, 1'b1, 3'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 2};
        t[2] = '{32'hFF800000, 1'b0, 3'd0, 32'h80000000, 1'b1, 1'b0, 2};
        t[3] = '{32'hFF800000, 1'b1, 3'd0, 32'h00000000, 1'b1, 1'b0, 2};
        t[4] = '{32'h7F800000, 1'b0, 3'd0, 32'h7FFFFFFF, 1'b1, 1'b0, 2};
        t[5] = '{32'h4F800000, 1'b1, 3'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 2};
        foreach (t[i]) begin
            run_conv(t[i].f, t[i].u, t[i].rm, ord, onv, onx, ob, lat);
            vectors++;
            if ({ord, onv, onx, ob} !== {t[i].rd, t[i].nv, t[i].nx, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL special[%0d] f=%h u=%b: rd=%h nv=%b nx=%b busy=%b, expected rd=%h nv=%b nx=%b busy=0",
                         i, t[i].f, t[i].u, ord, onv, onx, ob, t[i].rd, t[i].nv, t[i].nx);
            end
            vectors++;
            if (lat != t[i].lat) begin
                miscompares++;
                $display("[TB] FAIL special_latency[%0d]: got %0d edges, expected %0d", i, lat, t[i].lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ord;
        logic onv, onx, ob;
        int lat;
        run_conv(32'h40200000, 1'b0, 3'd0, ord, onv, onx, ob, lat);
        vectors++;
        if ({ord, onv, onx} !== {32'd2, 1'b0, 1'b1} || lat != 24) begin
            miscompares++;
            $display("[TB] FAIL b2b_first: rd=%h nv=%b nx=%b lat=%0d, expected rd=2 nv=0 nx=1 lat=24",
                     ord, onv, onx, lat);
        end
        run_conv(32'h3FC00000, 1'b0, 3'd1, ord, onv, onx, ob, lat);
        vectors++;
        if ({ord, onv, onx} !== {32'd1, 1'b0, 1'b1} || lat != 25) begin
            miscompares++;
            $display("[TB] FAIL b2b_second: rd=%h nv=%b nx=%b lat=%0d, expected rd=1 nv=0 nx=1 lat=25",
                     ord, onv, onx, lat);
        end
        @(posedge CLK);
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.rd !== 32'd1 || bus.nx !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_hold: ov=%b rd=%h nx=%b, expected ov=0 rd=1 nx=1",
                     bus.out_valid, bus.rd, bus.nx);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] ord;
        logic onv, onx, ob;
        int lat;
        logic seen;
        bus.f           = 32'h3F800000;
        bus.is_unsigned = 1'b0;
        bus.rm          = 3'd0;
        bus.in_valid    = 1'b1;
        @(posedge CLK);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        vectors++;
        if ({bus.busy, bus.out_valid, bus.rd, bus.nv, bus.nx} !== 36'd0) begin
            miscompares++;
            $display("[TB] FAIL abort_async: busy=%b ov=%b rd=%h nv=%b nx=%b, expected all zero",
                     bus.busy, bus.out_valid, bus.rd, bus.nv, bus.nx);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(posedge CLK);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        vectors++;
        if (seen || bus.rd !== 32'd0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_quiet: ov_seen=%b rd=%h busy=%b, expected ov_seen=0 rd=0 busy=0",
                     seen, bus.rd, bus.busy);
        end

        // A request held high while busy must not restart or queue behind the running one.
        bus.f        = 32'h40200000;
        bus.rm       = 3'd0;
        bus.in_valid = 1'b1;
        @(posedge CLK);
        #1;
        bus.f = 32'h3F800000;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge CLK);
            #1;
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.rd !== 32'd2 || bus.nx !== 1'b1 || lat != 24) begin
            miscompares++;
            $display("[TB] FAIL held_request: rd=%h nx=%b lat=%0d, expected rd=2 nx=1 lat=24",
                     bus.rd, bus.nx, lat);
        end
        run_conv(32'h3F800000, 1'b0, 3'd0, ord, onv, onx, ob, lat);
        vectors++;
        if ({ord, onv, onx} !== {32'd1, 1'b0, 1'b0} || lat != 25) begin
            miscompares++;
            $display("[TB] FAIL after_abort: rd=%h nv=%b nx=%b lat=%0d, expected rd=1 nv=0 nx=0 lat=25",
                     ord, onv, onx, lat);
        end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_limits();
        test_special();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
